// File: rtl/clock_pkg.sv
// Shared types and constants for the seconds/minutes clock datapath and its decoders.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MIN = 2'd1,
    SET_SEC = 2'd2
  } state_t;

  localparam int unsigned TIME_W      = 6;
  localparam int unsigned SEC_PER_MIN = 60;
  localparam int unsigned MIN_PER_HR  = 60;

  // Modulo increment for a time field; wraps to zero at the field's limit.
  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                 input int unsigned modulus);
    return (32'(v) == modulus - 1) ? '0 : v + TIME_W'(1);
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button inputs and time/display outputs of the clock mode controller.
interface clock_set_ctrl_if;
  import clock_pkg::*;

  logic              btn_mode;
  logic              btn_inc;
  logic [TIME_W-1:0] sec;
  logic [TIME_W-1:0] min;
  logic              running;
  logic              tick_1hz;
  logic              blink_min;
  logic              blink_sec;

  modport master (
    output btn_mode, btn_inc,
    input  sec, min, running, tick_1hz, blink_min, blink_sec
  );

  modport slave (
    input  btn_mode, btn_inc,
    output sec, min, running, tick_1hz, blink_min, blink_sec
  );
endinterface

// File: rtl/edge_rise.sv
// Registered rising-edge detector; the history register tracks the button through
// reset so a button held across reset release yields no edge.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise_c
);

  logic btn_q;

  always_ff @(posedge clk) begin
    btn_q <= btn;
  end

  assign rise_c = btn & ~btn_q & ~reset;

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set mode FSM, 1 Hz prescaler, blink phase generator and minute/second counters.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  clock_set_ctrl_if.slave  bus
);

  localparam int unsigned PW   = $clog2(CLK_HZ);
  localparam int unsigned HALF = CLK_HZ / 2;
  localparam int unsigned BW   = $clog2(HALF);

  state_t            state, state_next;
  logic [PW-1:0]     presc, presc_next;
  logic [BW-1:0]     bcnt, bcnt_next;
  logic              phase, phase_next;
  logic [TIME_W-1:0] sec_cnt, sec_next;
  logic [TIME_W-1:0] min_cnt, min_next;
  logic              running, running_next;
  logic              tick, tick_next;
  logic              blink_min, blink_min_next;
  logic              blink_sec, blink_sec_next;
  logic              mode_rise_c, inc_rise_c;

  edge_rise u_mode_edge (
    .clk    (clk),
    .reset  (reset),
    .btn    (bus.btn_mode),
    .rise_c (mode_rise_c)
  );

  edge_rise u_inc_edge (
    .clk    (clk),
    .reset  (reset),
    .btn    (bus.btn_inc),
    .rise_c (inc_rise_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      presc     <= '0;
      bcnt      <= '0;
      phase     <= 1'b0;
      sec_cnt   <= '0;
      min_cnt   <= '0;
      running   <= 1'b1;
      tick      <= 1'b0;
      blink_min <= 1'b0;
      blink_sec <= 1'b0;
    end else begin
      state     <= state_next;
      presc     <= presc_next;
      bcnt      <= bcnt_next;
      phase     <= phase_next;
      sec_cnt   <= sec_next;
      min_cnt   <= min_next;
      running   <= running_next;
      tick      <= tick_next;
      blink_min <= blink_min_next;
      blink_sec <= blink_sec_next;
    end
  end

  always_comb begin
    state_next = state;
    presc_next = presc;
    sec_next   = sec_cnt;
    min_next   = min_cnt;
    tick_next  = 1'b0;

    unique case (state)
      RUN: begin
        // A tick coinciding with a mode edge is still applied.
        if (presc == PW'(CLK_HZ - 1)) begin
          presc_next = '0;
          tick_next  = 1'b1;
          sec_next   = wrap_inc(sec_cnt, SEC_PER_MIN);
          if (32'(sec_cnt) == SEC_PER_MIN - 1) begin
            min_next = wrap_inc(min_cnt, MIN_PER_HR);
          end
        end else begin
          presc_next = presc + PW'(1);
        end
        if (mode_rise_c) begin
          state_next = SET_MIN;
          presc_next = '0;
        end
      end
      SET_MIN: begin
        presc_next = '0;
        if (mode_rise_c) begin
          state_next = SET_SEC;
        end else if (inc_rise_c) begin
          min_next = wrap_inc(min_cnt, MIN_PER_HR);
        end
      end
      SET_SEC: begin
        presc_next = '0;
        if (mode_rise_c) begin
          state_next = RUN;
        end else if (inc_rise_c) begin
          sec_next = wrap_inc(sec_cnt, SEC_PER_MIN);
        end
      end
      default: begin
        state_next = RUN;
        presc_next = '0;
      end
    endcase

    // Half-second phase restarts from low on every state change.
    if (state_next != state) begin
      bcnt_next  = '0;
      phase_next = 1'b0;
    end else if (bcnt == BW'(HALF - 1)) begin
      bcnt_next  = '0;
      phase_next = ~phase;
    end else begin
      bcnt_next  = bcnt + BW'(1);
      phase_next = phase;
    end

    running_next   = (state_next == RUN);
    blink_min_next = (state_next == SET_MIN) & phase_next;
    blink_sec_next = (state_next == SET_SEC) & phase_next;
  end

  assign bus.sec       = sec_cnt;
  assign bus.min       = min_cnt;
  assign bus.running   = running;
  assign bus.tick_1hz  = tick;
  assign bus.blink_min = blink_min;
  assign bus.blink_sec = blink_sec;

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode controller and time-keeping sequencer for the seconds/minutes clock datapath. It derives the 1 Hz tick from the system clock and owns the minute and second counters. Two front-panel buttons drive a run/set state machine that pauses time and lets the user adjust each field. Its binary `sec`/`min` outputs and blink flags feed the downstream BCD and 7-segment decode logic.

## Interface
- `CLK_HZ`, default 50_000_000: system clock cycles per second; must be an even number ≥ 4.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `btn_mode` input 1: mode button level, already synchronized and debounced upstream.
- `btn_inc` input 1: increment button level, already synchronized and debounced upstream.
- `sec` output 6: seconds, 0..59, binary.
- `min` output 6: minutes, 0..59, binary.
- `running` output 1: high when the state is RUN.
- `tick_1hz` output 1: one-cycle pulse for each second advanced in RUN.
- `blink_min` output 1: blanking flag for the minute digits; active in SET_MIN.
- `blink_sec` output 1: blanking flag for the second digits; active in SET_SEC.

## Operation
- **States:** RUN, SET_MIN, SET_SEC.
- **Transitions:**
  - A mode edge advances RUN → SET_MIN → SET_SEC → RUN.
  - No other transitions exist.
- **Edge detect:**
  - Per button: `rise = btn & ~btn_q`.
  - `btn_q` is registered every cycle.
  - During reset, `btn_q` loads the current button level, so a button held through reset produces no edge.
- **Prescaler:**
  - Counter width is `$clog2(CLK_HZ)` bits.
  - In RUN it counts 0..CLK_HZ-1 and wraps to 0.
  - In the SET states it is held at 0.
  - It is forced to 0 on the SET_SEC → RUN transition, so the first tick comes exactly CLK_HZ cycles after resuming.
- **Time advance:** in RUN, when the prescaler equals CLK_HZ-1:
  - `sec` increments.
  - If `sec` is 59, it wraps to 0 and `min` increments.
  - If `min` is 59, it wraps to 0; there is no hours carry.
- **Setting:**
  - An inc edge in SET_MIN increments `min` mod 60.
  - An inc edge in SET_SEC increments `sec` mod 60 with no carry into `min`.
  - Inc edges in RUN are ignored.
- **Simultaneous events:**
  - A mode edge and an inc edge in the same cycle: the mode edge wins and the inc edge is discarded.
  - A tick and a mode edge in the same cycle in RUN: the tick is applied and the state moves to SET_MIN.
- **Blink:**
  - A phase bit toggles every CLK_HZ/2 cycles of a separate half-second counter.
  - The counter and phase bit are cleared on every state change.
  - `blink_min = (state==SET_MIN) & phase`; `blink_sec = (state==SET_SEC) & phase`.
- **Reset values:**
  - State RUN.
  - `sec`=0, `min`=0, `running`=1, `tick_1hz`=0, `blink_min`=0, `blink_sec`=0.
  - Prescaler, blink counter and phase all 0.
- **Reset mid-operation:** applies in the cycle it is sampled and overrides every pending edge or tick.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Button effect: the state, `sec` or `min` changes at the first rising edge where the button is sampled high with `btn_q` low. The output is visible 1 cycle after the press is sampled.
- `tick_1hz` is high for exactly the cycle after the edge that advanced `sec`, and it coincides with the new `sec` value.
- In RUN after reset, the first tick edge is the CLK_HZ-th edge after reset deasserts.
- The first blink-high interval starts CLK_HZ/2 cycles after entering a SET state.

## Structure
- Package `clock_pkg` holds:
  - The `state_t` enum (RUN, SET_MIN, SET_SEC).
  - `SEC_PER_MIN = 60`, `MIN_PER_HR = 60`.
  - Shared use by the decoder blocks.
- One sub-module, `edge_rise`: a registered rising-edge detector with a load-on-reset input, instantiated once per button.
- The FSM, prescaler, blink counter and time counters live in `clock_set_ctrl`.

## Test plan
All scenarios use CLK_HZ=10.
- **Reset then run:** reset 2 cycles, then run 600 cycles → 60 `tick_1hz` pulses, exactly 10 cycles apart; `sec`=0, `min`=1.
- **Rollover:** preload via set mode to `min`=59, `sec`=59, return to RUN, wait 10 cycles → `sec`=0, `min`=0, one tick.
- **Set sequence:** mode edge, 3 inc edges, mode edge, 5 inc edges, mode edge → `min`=3, `sec`=5, `running`=1. The next tick comes exactly 10 cycles after the final mode edge.
- **Blink:** in SET_MIN, `blink_min` toggles every 5 cycles starting low; `blink_sec`=0. In SET_SEC the roles swap.
- **Simultaneous inputs:** mode and inc rise together in RUN → state SET_MIN with `min` unchanged. `btn_inc` held high for 20 cycles → exactly one increment.
- **Reset mid-set:** reset during SET_SEC with `btn_mode` held high → state RUN, `sec`=0, `min`=0, and no mode edge after reset releases.
